// File: rtl/polar_encoder_if.sv
// Handshake and data bundle between a frame source/sink and polar_encoder.
// Zero latency (wires only); in_valid/in_ready on input, out_valid/out_ready on output.
// Backpressure: in_ready and out_ready throttle each direction independently.
interface polar_encoder_if #(
    parameter int N = 8
);
    logic         start;
    logic [N-1:0] frozen_mask;
    logic         in_bit;
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] cw;
    logic         out_valid;
    logic         out_ready;
    logic         busy;

    modport master (
        output start, frozen_mask, in_bit, in_valid, out_ready,
        input  in_ready, cw, out_valid, busy
    );

    modport slave (
        input  start, frozen_mask, in_bit, in_valid, out_ready,
        output in_ready, cw, out_valid, busy
    );
endinterface

// File: rtl/polar_encoder.sv
// Polar encoder x = u*F^(xn), natural order; POLAR_ENC_SYSTEMATIC_EN adds a mask + second pass.
// Latency: last info bit to out_valid is LOG_N+1 cycles (2*LOG_N+2 when systematic).
// Backpressure: in_valid low stalls the load pointer; cw/out_valid hold until out_ready.
module polar_encoder #(
    parameter int N = 8
) (
    input logic            clk,
    input logic            rst,
    polar_encoder_if.slave bus
);
    localparam int LOG_N = $clog2(N);
    localparam logic [LOG_N-1:0] P_LAST = LOG_N'(N - 1);
    localparam logic [LOG_N-1:0] S_LAST = LOG_N'(LOG_N - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_ENC,
`ifdef POLAR_ENC_SYSTEMATIC_EN
        ST_MASK,
        ST_ENC2,
`endif
        ST_OUT
    } state_t;

    state_t           state_q, state_d;
    logic [N-1:0]     u_q, u_stage, u_rev;
    logic [N-1:0]     mask_q, mask_pos;
    logic [N-1:0]     cw_q;
    logic [LOG_N-1:0] p_q, s_q;
    logic             out_valid_q;
    logic             cur_frozen, load_adv, p_last, s_last;

    // Bit i of a stage-k mask is set where index i has bit k clear (upper butterfly leg).
    function automatic logic [N-1:0] lo_mask(input int k);
        logic [N-1:0] m;
        m = '0;
        for (int i = 0; i < N; i++) m[i] = ~i[k];
        return m;
    endfunction

    // Internal vectors are indexed by position; the bus carries position 0 at the MSB.
    always_comb begin
        mask_pos = '0;
        u_rev    = '0;
        for (int i = 0; i < N; i++) begin
            mask_pos[i]  = bus.frozen_mask[N-1-i];
            u_rev[N-1-i] = u_q[i];
        end
    end

    always_comb begin
        u_stage = u_q;
        for (int k = 0; k < LOG_N; k++)
            if (int'(s_q) == k) u_stage = u_q ^ ((u_q >> (1 << k)) & lo_mask(k));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (bus.start) state_d = ST_LOAD;
            ST_LOAD: if (load_adv && p_last) state_d = ST_ENC;
`ifdef POLAR_ENC_SYSTEMATIC_EN
            ST_ENC:  if (s_last) state_d = ST_MASK;
            ST_MASK: state_d = ST_ENC2;
            ST_ENC2: if (s_last) state_d = ST_OUT;
`else
            ST_ENC:  if (s_last) state_d = ST_OUT;
`endif
            ST_OUT:  if (out_valid_q && bus.out_ready) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        cur_frozen    = mask_q[p_q];
        p_last        = (p_q == P_LAST);
        s_last        = (s_q == S_LAST);
        load_adv      = (state_q == ST_LOAD) && (cur_frozen || bus.in_valid);
        bus.in_ready  = (state_q == ST_LOAD) && !cur_frozen;
        bus.busy      = (state_q != ST_IDLE);
        bus.out_valid = out_valid_q;
        bus.cw        = cw_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            u_q         <= '0;
            mask_q      <= '0;
            p_q         <= '0;
            s_q         <= '0;
            cw_q        <= '0;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: if (bus.start) begin
                    mask_q <= mask_pos;
                    u_q    <= '0;
                    p_q    <= '0;
                end
                ST_LOAD: begin
                    s_q <= '0;
                    if (load_adv) begin
                        u_q[p_q] <= bus.in_bit & ~cur_frozen;
                        p_q      <= p_q + 1'b1;
                    end
                end
                ST_ENC: begin
                    u_q <= u_stage;
                    s_q <= s_last ? '0 : s_q + 1'b1;
                end
`ifdef POLAR_ENC_SYSTEMATIC_EN
                ST_MASK: u_q <= u_q & ~mask_q;
                ST_ENC2: begin
                    u_q <= u_stage;
                    s_q <= s_last ? '0 : s_q + 1'b1;
                end
`endif
                // First OUT cycle registers the codeword; later cycles wait for the sink.
                ST_OUT: begin
                    if (!out_valid_q) begin
                        cw_q        <= u_rev;
                        out_valid_q <= 1'b1;
                    end else if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_polar_encoder.sv
// Self-checking bench for polar_encoder: directed vector table, hand-written corner cases
// and random frames against a generator-matrix reference model.
module tb_polar_encoder;
    localparam int N     = 8;
    localparam int LOG_N = 3;
`ifdef POLAR_ENC_SYSTEMATIC_EN
    localparam bit SYS     = 1'b1;
    localparam int ENC_CYC = 2 * LOG_N + 1;
`else
    localparam bit SYS     = 1'b0;
    localparam int ENC_CYC = LOG_N;
`endif

    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;

    polar_encoder_if #(.N(N)) bus ();
    polar_encoder #(.N(N)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    // info[j] is the j-th information bit sent on in_bit.
    typedef struct {
        logic [N-1:0] mask;
        logic [N-1:0] info;
        int           gap;
        int           hold;
        bit           poke;
        logic [N-1:0] exp_cw;
        logic [N-1:0] exp_sys;
    } vec_t;

    vec_t vecs[7];

    task automatic check(input string name, input longint got, input longint exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    // x[i] = XOR of u[j] over every j whose bits cover i (row structure of F^(xn)).
    function automatic logic [N-1:0] polar_tf(input logic [N-1:0] v);
        logic [N-1:0] x;
        x = '0;
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++)
                if ((j & i) == i) x[i] = x[i] ^ v[j];
        return x;
    endfunction

    function automatic logic [N-1:0] ref_cw(input logic [N-1:0] mask, input logic [N-1:0] info);
        logic [N-1:0] u, x, c;
        int j;
        u = '0;
        c = '0;
        j = 0;
        for (int i = 0; i < N; i++)
            if (!mask[N-1-i]) begin
                u[i] = info[j];
                j++;
            end
        x = polar_tf(u);
        if (SYS) begin
            for (int i = 0; i < N; i++) if (mask[N-1-i]) x[i] = 1'b0;
            x = polar_tf(x);
        end
        for (int i = 0; i < N; i++) c[N-1-i] = x[i];
        return c;
    endfunction

    // Called at a negedge with the encoder idle; returns at a negedge with it idle again.
    task automatic run_frame(input logic [N-1:0] mask, input logic [N-1:0] info,
                             input int gap, input int hold, input bit poke,
                             output logic [N-1:0] got, output int lat, output int acc,
                             output int tcyc, output bit saw_rdy, output bit unstable,
                             output bit idle_ok, output bit tmo);
        int  cyc, last, k;
        bit  v;
        k        = N - $countones(mask);
        cyc      = 0;
        last     = -1;
        acc      = 0;
        saw_rdy  = 1'b0;
        unstable = 1'b0;
        tmo      = 1'b0;
        bus.start       = 1'b1;
        bus.frozen_mask = mask;
        bus.in_valid    = 1'b0;
        bus.out_ready   = 1'b0;
        @(negedge clk);
        bus.start       = 1'b0;
        bus.frozen_mask = ~mask;
        while (!bus.out_valid) begin
            if (cyc > 500) begin
                tmo = 1'b1;
                break;
            end
            case (gap)
                1:       v = (cyc % 2 == 0);
                2:       v = ($urandom_range(0, 2) != 0);
                default: v = 1'b1;
            endcase
            bus.in_valid = v;
            bus.in_bit   = (acc < N) ? info[acc] : 1'b1;
            bus.start    = poke && (last >= 0) && (acc == k) && (cyc == last + 1 || cyc == last + 2);
            bus.frozen_mask = bus.start ? '0 : ~mask;
            if (bus.in_ready) saw_rdy = 1'b1;
            if (bus.in_ready && bus.in_valid) begin
                acc++;
                last = cyc;
            end
            @(negedge clk);
            cyc++;
        end
        bus.in_valid = 1'b0;
        bus.start    = 1'b0;
        lat  = cyc - last - 1;
        tcyc = cyc;
        got  = bus.cw;
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            if (bus.cw !== got || bus.out_valid !== 1'b1) unstable = 1'b1;
        end
        // start during the handshake cycle must be ignored.
        bus.out_ready   = 1'b1;
        bus.start       = 1'b1;
        bus.frozen_mask = '1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        bus.start     = 1'b0;
        idle_ok = (bus.busy === 1'b0) && (bus.out_valid === 1'b0);
    endtask

    initial begin
        logic [N-1:0] got;
        int           lat, acc, tcyc, k, nacc;
        bit           saw, unstable, idle_ok, tmo;
        logic [N-1:0] m, inf;

        rst             = 1'b1;
        bus.start       = 1'b0;
        bus.frozen_mask = '0;
        bus.in_bit      = 1'b0;
        bus.in_valid    = 1'b0;
        bus.out_ready   = 1'b0;

        vecs[0] = '{8'hE8, 8'h01, 0, 0,  1'b0, 8'hF0, 8'hF0};
        vecs[1] = '{8'hE8, 8'h0F, 0, 0,  1'b0, 8'h69, 8'hFF};
        vecs[2] = '{8'hE8, 8'h01, 1, 0,  1'b0, 8'hF0, 8'hF0};
        vecs[3] = '{8'hE8, 8'h0F, 0, 10, 1'b0, 8'h69, 8'hFF};
        vecs[4] = '{8'hE8, 8'h0F, 0, 0,  1'b1, 8'h69, 8'hFF};
        vecs[5] = '{8'hFF, 8'h00, 0, 0,  1'b0, 8'h00, 8'h00};
        vecs[6] = '{8'h00, 8'h80, 0, 0,  1'b0, 8'hFF, 8'h01};

        repeat (2) @(negedge clk);
        check("rst_cw", bus.cw, 0);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_in_ready", bus.in_ready, 0);
        check("rst_busy", bus.busy, 0);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 7; i++) begin
            k = N - $countones(vecs[i].mask);
            run_frame(vecs[i].mask, vecs[i].info, vecs[i].gap, vecs[i].hold, vecs[i].poke,
                      got, lat, acc, tcyc, saw, unstable, idle_ok, tmo);
            check($sformatf("v%0d_timeout", i), tmo, 0);
            check($sformatf("v%0d_cw", i), got, SYS ? vecs[i].exp_sys : vecs[i].exp_cw);
            check($sformatf("v%0d_model", i), got, ref_cw(vecs[i].mask, vecs[i].info));
            check($sformatf("v%0d_accepted", i), acc, k);
            check($sformatf("v%0d_idle_after", i), idle_ok, 1);
            if (!vecs[i].mask[0]) check($sformatf("v%0d_latency", i), lat, ENC_CYC + 1);
            if (vecs[i].hold > 0) check($sformatf("v%0d_hold_stable", i), unstable, 0);
            if (vecs[i].mask == '1) begin
                check($sformatf("v%0d_no_in_ready", i), saw, 0);
                check($sformatf("v%0d_frame_cycles", i), tcyc, N + ENC_CYC + 1);
            end
        end

        // Reset in the middle of LOAD after two accepted bits.
        bus.start       = 1'b1;
        bus.frozen_mask = 8'hE8;
        @(negedge clk);
        bus.start    = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_bit   = 1'b1;
        nacc = 0;
        for (int c = 0; c < 40 && nacc < 2; c++) begin
            if (bus.in_ready) nacc++;
            @(negedge clk);
        end
        check("rstload_accepted", nacc, 2);
        rst = 1'b1;
        #1;
        check("rstload_cw", bus.cw, 0);
        check("rstload_out_valid", bus.out_valid, 0);
        check("rstload_in_ready", bus.in_ready, 0);
        check("rstload_busy", bus.busy, 0);
        @(negedge clk);
        rst          = 1'b0;
        bus.in_valid = 1'b0;
        @(negedge clk);
        run_frame(8'hE8, 8'h0F, 0, 0, 1'b0, got, lat, acc, tcyc, saw, unstable, idle_ok, tmo);
        check("after_rst_timeout", tmo, 0);
        check("after_rst_cw", got, SYS ? 8'hFF : 8'h69);

        for (int r = 0; r < 40; r++) begin
            m   = N'($urandom);
            inf = N'($urandom);
            k   = N - $countones(m);
            run_frame(m, inf, $urandom_range(0, 2), $urandom_range(0, 3), 1'b0,
                      got, lat, acc, tcyc, saw, unstable, idle_ok, tmo);
            check($sformatf("rnd%0d_timeout", r), tmo, 0);
            check($sformatf("rnd%0d_cw", r), got, ref_cw(m, inf));
            check($sformatf("rnd%0d_accepted", r), acc, k);
            check($sformatf("rnd%0d_idle_after", r), idle_ok, 1);
            check($sformatf("rnd%0d_hold_stable", r), unstable, 0);
            if (!m[0]) check($sformatf("rnd%0d_latency", r), lat, ENC_CYC + 1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
